// File: rtl/freecell_move_entry_if.sv
// freecell_move_entry_if: player slot selections in, source/dest move handshake out to the engine
interface freecell_move_entry_if #(parameter int COUNT_W = 10);
  logic [3:0] slot_sel;
  logic sel_strobe;
  logic cancel;
  logic game_won;
  logic move_ack;
  logic move_ok;
  logic [3:0] source;
  logic [3:0] dest;
  logic move_valid;
  logic src_held;
  logic reject;
  logic illegal;
  logic timeout;
  logic [COUNT_W-1:0] move_count;
  modport master (
    output slot_sel, sel_strobe, cancel, game_won, move_ack, move_ok,
    input source, dest, move_valid, src_held, reject, illegal, timeout, move_count
  );
  modport slave (
    input slot_sel, sel_strobe, cancel, game_won, move_ack, move_ok,
    output source, dest, move_valid, src_held, reject, illegal, timeout, move_count
  );
endinterface

// File: rtl/freecell_move_entry.sv
// freecell_move_entry: turns slot strobes into a source-then-dest move presented to the FreeCell engine
module freecell_move_entry #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int COUNT_W = 10
) (
  input logic clock,
  input logic reset,
  freecell_move_entry_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, SRC, ISSUE, LOCKED} state_t;
  state_t state, state_n;
  logic [3:0] src, src_n, dst, dst_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [COUNT_W-1:0] count, count_n;
  logic reject, reject_n, illegal, illegal_n, timeout, timeout_n;
  always_comb begin
    state_n = state;
    src_n = src;
    dst_n = dst;
    cnt_n = cnt;
    count_n = count;
    reject_n = 1'b0;
    illegal_n = 1'b0;
    timeout_n = 1'b0;
    if (bus.game_won) state_n = LOCKED;
    else case (state)
      IDLE: if (bus.sel_strobe) begin
        if (&bus.slot_sel[3:2]) reject_n = 1'b1;
        else begin
          src_n = bus.slot_sel;
          cnt_n = '0;
          state_n = SRC;
        end
      end
      SRC: begin
        cnt_n = cnt + 1'b1;
        if (bus.cancel) state_n = IDLE;
        else if (bus.sel_strobe) begin
          // re-pressing the held source deselects it instead of issuing a no-op move
          if (bus.slot_sel == src) state_n = IDLE;
          else begin
            dst_n = bus.slot_sel;
            state_n = ISSUE;
          end
        end else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
          state_n = IDLE;
          timeout_n = 1'b1;
        end
      end
      ISSUE: if (bus.move_ack) begin
        state_n = IDLE;
        count_n = count + COUNT_W'(bus.move_ok);
        illegal_n = !bus.move_ok;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      cnt <= '0;
      count <= '0;
      reject <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      src <= src_n;
      dst <= dst_n;
      cnt <= cnt_n;
      count <= count_n;
      reject <= reject_n;
      illegal <= illegal_n;
      timeout <= timeout_n;
    end
  end
  assign bus.source = src;
  assign bus.dest = dst;
  assign bus.move_valid = state == ISSUE;
  assign bus.src_held = state == SRC || state == ISSUE;
  assign bus.reject = reject;
  assign bus.illegal = illegal;
  assign bus.timeout = timeout;
  assign bus.move_count = count;
endmodule

// File: tb/tb_freecell_move_entry.sv
// tb_freecell_move_entry: directed scenarios plus random play against a behavioural move-entry model
module tb_freecell_move_entry;
  localparam int T = 8;
  localparam int CW = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  freecell_move_entry_if #(.COUNT_W(CW)) bus ();
  freecell_move_entry #(.TIMEOUT_CYC(T), .COUNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0;
  int passed = 0;
  bit armed = 0;
  bit m_locked, m_hold, m_pres, m_rej, m_ill, m_to;
  int m_src, m_dst, m_count, m_since;
  int m_edge = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask
  // behavioural model: hold/present flags and an absolute expiry edge instead of a counter
  always @(posedge clock) begin
    m_rej = 0;
    m_ill = 0;
    m_to = 0;
    if (reset) begin
      m_locked = 0;
      m_hold = 0;
      m_pres = 0;
      m_src = 0;
      m_dst = 0;
      m_count = 0;
      armed = 1;
    end else if (bus.game_won) begin
      m_locked = 1;
      m_hold = 0;
      m_pres = 0;
    end else if (!m_locked) begin
      if (m_pres) begin
        if (bus.move_ack) begin
          m_pres = 0;
          m_hold = 0;
          if (bus.move_ok) m_count = (m_count + 1) % (1 << CW);
          else m_ill = 1;
        end
      end else if (m_hold) begin
        if (bus.cancel) m_hold = 0;
        else if (bus.sel_strobe) begin
          if (int'(bus.slot_sel) == m_src) m_hold = 0;
          else begin
            m_dst = int'(bus.slot_sel);
            m_pres = 1;
          end
        end else if (m_edge - m_since == T) begin
          m_hold = 0;
          m_to = 1;
        end
      end else if (bus.sel_strobe) begin
        if (bus.slot_sel >= 4'd12) m_rej = 1;
        else begin
          m_src = int'(bus.slot_sel);
          m_hold = 1;
          m_since = m_edge;
        end
      end
    end
    m_edge++;
  end
  always @(negedge clock) if (armed) begin
    chk("source", bus.source, m_src);
    chk("dest", bus.dest, m_dst);
    chk("move_valid", bus.move_valid, m_pres);
    chk("src_held", bus.src_held, m_hold);
    chk("reject", bus.reject, m_rej);
    chk("illegal", bus.illegal, m_ill);
    chk("timeout", bus.timeout, m_to);
    chk("move_count", bus.move_count, m_count);
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic press(input logic [3:0] s);
    bus.slot_sel = s;
    bus.sel_strobe = 1'b1;
    tick();
    bus.sel_strobe = 1'b0;
  endtask
  task automatic ack(input bit ok);
    bus.move_ack = 1'b1;
    bus.move_ok = ok;
    tick();
    bus.move_ack = 1'b0;
    bus.move_ok = 1'b0;
  endtask
  initial begin
    bus.slot_sel = '0;
    bus.sel_strobe = 1'b0;
    bus.cancel = 1'b0;
    bus.game_won = 1'b0;
    bus.move_ack = 1'b0;
    bus.move_ok = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.move_valid, 0);
    chk("rst_held", bus.src_held, 0);
    chk("rst_count", bus.move_count, 0);
    chk("rst_source", bus.source, 0);
    reset = 1'b0;
    press(4'b0000);
    chk("basic_held", bus.src_held, 1);
    press(4'b1001);
    chk("basic_valid", bus.move_valid, 1);
    chk("basic_source", bus.source, 0);
    chk("basic_dest", bus.dest, 9);
    ack(1);
    chk("basic_done_valid", bus.move_valid, 0);
    chk("basic_count", bus.move_count, 1);
    chk("model_count", m_count, 1);
    press(4'b1110);
    chk("home_reject", bus.reject, 1);
    chk("home_held", bus.src_held, 0);
    tick();
    chk("reject_pulse", bus.reject, 0);
    press(4'b0011);
    press(4'b0011);
    chk("desel_held", bus.src_held, 0);
    chk("desel_valid", bus.move_valid, 0);
    press(4'b0010);
    press(4'b0101);
    ack(0);
    chk("illegal_pulse", bus.illegal, 1);
    chk("illegal_count", bus.move_count, 1);
    tick();
    chk("illegal_one", bus.illegal, 0);
    press(4'b0001);
    repeat (T - 1) tick();
    chk("pre_timeout_held", bus.src_held, 1);
    chk("pre_timeout", bus.timeout, 0);
    tick();
    chk("timeout_pulse", bus.timeout, 1);
    chk("timeout_held", bus.src_held, 0);
    tick();
    chk("timeout_one", bus.timeout, 0);
    press(4'b0001);
    bus.cancel = 1'b1;
    press(4'b0100);
    bus.cancel = 1'b0;
    chk("cancel_wins_held", bus.src_held, 0);
    chk("cancel_wins_valid", bus.move_valid, 0);
    press(4'b0000);
    press(4'b0110);
    bus.cancel = 1'b1;
    press(4'b0111);
    bus.cancel = 1'b0;
    chk("issue_ign_valid", bus.move_valid, 1);
    chk("issue_ign_dest", bus.dest, 6);
    repeat (50) tick();
    chk("ack_wait_valid", bus.move_valid, 1);
    ack(1);
    chk("count2", bus.move_count, 2);
    press(4'b0100);
    press(4'b1000);
    ack(1);
    chk("count3", bus.move_count, 3);
    press(4'b0101);
    press(4'b1111);
    ack(1);
    chk("count_wrap", bus.move_count, 0);
    press(4'b0001);
    press(4'b0010);
    bus.game_won = 1'b1;
    tick();
    bus.game_won = 1'b0;
    chk("lock_valid", bus.move_valid, 0);
    chk("lock_held", bus.src_held, 0);
    press(4'b0011);
    chk("lock_strobe", bus.src_held, 0);
    ack(1);
    chk("lock_count", bus.move_count, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    press(4'b0100);
    press(4'b0101);
    chk("pre_reset_valid", bus.move_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_issue_valid", bus.move_valid, 0);
    chk("reset_issue_held", bus.src_held, 0);
    chk("reset_issue_dest", bus.dest, 0);
    for (int i = 0; i < 4000; i++) begin
      bus.sel_strobe = ((i / 500) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      bus.slot_sel = 4'($urandom_range(0, 15));
      bus.cancel = $urandom_range(0, 15) == 0;
      bus.move_ack = $urandom_range(0, 2) == 0;
      bus.move_ok = 1'($urandom_range(0, 1));
      bus.game_won = $urandom_range(0, 299) == 0;
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    bus.sel_strobe = 1'b0;
    bus.cancel = 1'b0;
    bus.move_ack = 1'b0;
    bus.game_won = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/freecell_move_entry.md
Name: freecell_move_entry

Overview:
- Move-entry front end that drives the `source`/`dest` move interface of the FreeCell game engine.
- Converts a stream of player slot selections (one strobe per button press) into a two-step source-then-destination move.
- Presents the move to the engine with a valid/ack handshake and tracks the engine's verdict and move count.
- Sits between the debounced button/keypad logic and the game engine.

Parameters:
- TIMEOUT_CYC, 1000, cycles a held source selection survives without a destination press before auto-cancel (>=2).
- COUNT_W, 10, width of the legal-move counter.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- slot_sel  input  4  selected slot, engine encoding: 0ccc = tableau column ccc, 10ff = free cell ff, 11hh = home hh.
- sel_strobe  input  1  single-cycle pulse; slot_sel is valid on this cycle.
- cancel  input  1  single-cycle pulse; abandons a held source.
- game_won  input  1  engine win flag; level.
- move_ack  input  1  engine has processed the presented move; single cycle.
- move_ok  input  1  engine verdict, valid only when move_ack=1 (1 = legal, applied).
- source  output  4  source slot presented to the engine.
- dest  output  4  destination slot presented to the engine.
- move_valid  output  1  source/dest pair is valid; held until ack.
- src_held  output  1  a source is selected and a destination is awaited (LED).
- reject  output  1  one-cycle pulse: home slot chosen as source.
- illegal  output  1  one-cycle pulse: engine rejected the move.
- timeout  output  1  one-cycle pulse: source selection expired.
- move_count  output  COUNT_W  number of legal moves accepted.

Behaviour:
- Reset values:
  - source=0, dest=0, move_valid=0, src_held=0.
  - reject=0, illegal=0, timeout=0.
  - move_count=0, timeout counter=0, state=IDLE.
  - Reset mid-ISSUE drops move_valid on the next edge; the in-flight move is abandoned.
- States: IDLE, SRC, ISSUE, LOCKED.
- Priority each cycle: reset > game_won > state logic.
- game_won=1 in any state goes to LOCKED on the next edge:
  - move_valid=0, src_held=0.
  - Strobes are ignored.
  - LOCKED is left only by reset.
- IDLE:
  - sel_strobe with slot_sel[3:2]==2'b11 → stay IDLE, reject=1 for one cycle.
  - sel_strobe with any other slot → source<=slot_sel, go to SRC, src_held=1, timeout counter cleared.
  - cancel is ignored.
- SRC:
  - Timeout counter increments every cycle.
  - cancel=1 → IDLE, src_held=0.
  - sel_strobe with slot_sel==source → deselect: IDLE, no move issued.
  - sel_strobe with any other slot (home allowed) → dest<=slot_sel, go to ISSUE.
  - Strobe and cancel on the same cycle → cancel wins.
  - Counter reaches TIMEOUT_CYC-1 with no strobe/cancel → IDLE, timeout=1 for one cycle.
  - A strobe on the expiry cycle is processed; timeout is not pulsed.
- ISSUE:
  - move_valid=1 from the first ISSUE cycle (registered, one cycle after the dest strobe); src_held stays 1.
  - source and dest are stable while move_valid=1.
  - sel_strobe and cancel are ignored.
  - move_ack=1 → move_valid=0 next edge, go to IDLE, src_held=0.
    - If move_ok=1: move_count+1, wrapping from 2^COUNT_W-1 to 0.
    - If move_ok=0: illegal=1 for one cycle.
  - move_ack arriving in the same cycle move_valid first rises is legal and honoured.
  - move_ack while not in ISSUE is ignored.
  - No ack timeout: ISSUE waits indefinitely.
- source/dest hold their last values after a move completes; only move_valid qualifies them.
- Minimum move latency: dest strobe at edge N → move_valid at N+1 → ack at N+1 → IDLE at N+2.

Test Plan:
- Basic legal move: strobe 4'b0000, then strobe 4'b1001 → move_valid=1 with source=0000, dest=1001; ack with ok=1 → move_valid=0, move_count=1, state IDLE.
- Rejects: strobe 4'b1110 in IDLE → reject pulse, src_held=0. Strobe 0011 then 0011 again → back to IDLE, no move_valid.
- Illegal move from engine: 0010 → 0101 presented; move_ack=1, move_ok=0 → illegal pulse for exactly one cycle, move_count unchanged.
- Timeout and cancel (TIMEOUT_CYC=8):
  - Strobe 0001 then idle 8 cycles → timeout pulse, IDLE.
  - Strobe 0001 then cancel+strobe 0100 on the same cycle → IDLE, no move.
- Handshake robustness: during ISSUE, strobe 0111 and cancel → ignored, source/dest unchanged. Hold ack low for 50 cycles → move_valid stays 1.
- Lockout, reset and wrap:
  - game_won=1 mid-ISSUE → LOCKED, move_valid=0, strobes ignored until reset.
  - With COUNT_W=2, four legal moves → move_count wraps to 0.
  - Reset during ISSUE → all outputs return to reset values next edge.
